fifo_sync_rewind: RTL and testbench
===================================

// Module: fifo_sync_rewind
// PURPOSE
//  Single-clock, parametrised FIFO for the CNN datapath (line/kernel buffering between conv stages).
//  Adds full/empty/almost flags, occupancy count, registered read with valid, and mark/rewind
//  so a window of entries can be re-read for kernel reuse.
//  Sticky overflow/underflow error flags.
// PARAMETERS
//  DATA_WIDTH   16  width of one entry
//  DEPTH        16  number of entries, >=2, any integer (not only powers of 2)
//  ADDR_WIDTH   $clog2(DEPTH)  pointer width (derived; do not override)
//  AFULL_THR    DEPTH-2  almost_full asserts when held >= AFULL_THR
//  AEMPTY_THR   2   almost_empty asserts when count <= AEMPTY_THR
// PORTS
//  clk           in   1           single clock, all logic on posedge
//  rst_n         in   1           synchronous, active-low reset
//  wr_en         in   1           write request
//  data_in       in   DATA_WIDTH  write data
//  rd_en         in   1           read request
//  data_out      out  DATA_WIDTH  read data, valid when rd_valid=1
//  rd_valid      out  1           data_out carries the entry read on the previous cycle
//  rd_mark       in   1           capture current rd_ptr as mark, hold marked entries
//  rd_rewind     in   1           restore rd_ptr to mark (ignored if no mark active)
//  rd_release    in   1           drop mark, free held entries
//  full          out  1           held == DEPTH
//  empty         out  1           count == 0
//  almost_full   out  1           held >= AFULL_THR
//  almost_empty  out  1           count <= AEMPTY_THR
//  count         out  ADDR_WIDTH+1  unread entries (wr_ptr - rd_ptr)
//  overflow      out  1           sticky: write attempted while full
//  underflow     out  1           sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pointers, mark, count, held = 0; data_out=0, rd_valid=0,
//    overflow=underflow=0, empty=1, full=0. Memory contents are not cleared.
//  - Reset applies mid-operation regardless of other inputs, and takes effect at that same edge.
//  - Pointers wrap from DEPTH-1 to 0.
//  - base = mark_active ? mark_ptr : rd_ptr.
//  - held = entries from base to wr_ptr, range 0..DEPTH; full/almost_full use held.
//  - Write accepted iff wr_en && !full: mem[wr_ptr] <= data_in, wr_ptr++.
//  - wr_en && full: no write; overflow <= 1.
//  - Read accepted iff rd_en && !empty && !rd_rewind_eff: data_out <= mem[rd_ptr] next edge,
//    rd_valid=1 for exactly that cycle, rd_ptr++.
//  - No accepted read: rd_valid=0 and data_out holds its last value (no zeroing).
//  - rd_en && empty: underflow <= 1.
//  - Read latency is 1 cycle.
//  - Simultaneous read+write: both accepted per own rules.
//  - At full, read frees space only next cycle; same-cycle write is rejected.
//  - At empty, a write is not readable until the following cycle (no fall-through).
//  - rd_mark: mark_ptr <= rd_ptr (the pre-increment value if a read occurs the same cycle);
//    mark_active <= 1; re-mark overwrites the mark.
//  - rd_rewind_eff = rd_rewind && mark_active: rd_ptr <= mark_ptr; any same-cycle read is dropped
//    (no rd_valid, no underflow); count recomputed. Mark stays active.
//  - rd_release: mark_active <= 0 and held collapses to count.
//  - Priority within one cycle: rd_rewind > rd_mark > rd_release.
//    Lower-priority mark/release inputs are ignored that cycle.
//  - Flags and count are registered and reflect all accepted operations of the previous edge.
//  - Sticky error flags clear only on reset.
// TESTING
//  1. DEPTH=16: write 0..15 -> full=1, almost_full=1 at 14 entries.
//     Read 16 -> data 0..15 on consecutive rd_valid cycles, 1-cycle latency, then empty=1.
//  2. Wrap: DEPTH=10 (non-power-of-2), stream 25 writes/reads interleaved
//     -> order preserved, count never exceeds 10.
//  3. Full with rd_en+wr_en same cycle -> read accepted, write rejected, overflow=1, count=DEPTH-1.
//  4. Mark after 3 reads, read 4, rewind -> next 4 reads return entries 3..6 again.
//     held stays at 16 while marked (writes blocked, full=1); rd_release -> full=0.
//  5. rd_en on empty -> underflow=1, rd_valid=0, data_out unchanged.
//     Rewind with rd_en same cycle -> no rd_valid.
//  6. rst_n=0 mid-stream with wr_en=rd_en=1 -> next cycle count=0, empty=1, flags 0, rd_valid=0.

Source files
------------

// File: rtl/fifo_sync_rewind.sv
// Single-clock FIFO with registered read, occupancy flags and mark/rewind
// so a window of already-read entries can be replayed for kernel reuse.
module fifo_sync_rewind #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  input  logic                  rd_mark,
  input  logic                  rd_rewind,
  input  logic                  rd_release,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  ptr_t                  mark_ptr_q, mark_ptr_d;
  logic                  mark_active_q, mark_active_d;
  cnt_t                  count_q, count_d;
  cnt_t                  held_q, held_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic rewind_eff;
  logic wr_acc;
  logic rd_acc;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mark_ptr_d    = mark_ptr_q;
    mark_active_d = mark_active_q;
    count_d       = count_q;
    held_d        = held_q;
    data_out_d    = data_out_q;
    rd_valid_d    = 1'b0;
    ovf_d         = ovf_q;
    udf_d         = udf_q;

    rewind_eff = rd_rewind && mark_active_q;
    wr_acc     = wr_en && !full_q;
    rd_acc     = rd_en && !empty_q && !rewind_eff;

    if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);

    if (rewind_eff)  rd_ptr_d = mark_ptr_q;
    else if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);

    if (rd_acc) data_out_d = mem_q[rd_ptr_q];
    rd_valid_d = rd_acc;

    if (wr_en && full_q) ovf_d = 1'b1;
    if (rd_en && empty_q && !rewind_eff) udf_d = 1'b1;

    // After a rewind the unread window is exactly the held window.
    if (rewind_eff) count_d = held_q + cnt_t'(wr_acc);
    else            count_d = count_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);

    if (rewind_eff) begin
      held_d = held_q + cnt_t'(wr_acc);
    end else if (rd_mark) begin
      mark_ptr_d    = rd_ptr_q;
      mark_active_d = 1'b1;
      held_d        = count_q + cnt_t'(wr_acc);
    end else if (rd_release) begin
      mark_active_d = 1'b0;
      held_d        = count_d;
    end else if (mark_active_q) begin
      held_d = held_q + cnt_t'(wr_acc);
    end else begin
      held_d = count_d;
    end

    full_d   = (held_d == cnt_t'(DEPTH));
    afull_d  = (held_d >= cnt_t'(AFULL_THR));
    empty_d  = (count_d == '0);
    aempty_d = (count_d <= cnt_t'(AEMPTY_THR));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mark_ptr_q    <= '0;
      mark_active_q <= 1'b0;
      count_q       <= '0;
      held_q        <= '0;
      data_out_q    <= '0;
      rd_valid_q    <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      afull_q       <= (AFULL_THR <= 0);
      aempty_q      <= 1'b1;
      ovf_q         <= 1'b0;
      udf_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mark_ptr_q    <= mark_ptr_d;
      mark_active_q <= mark_active_d;
      count_q       <= count_d;
      held_q        <= held_d;
      data_out_q    <= data_out_d;
      rd_valid_q    <= rd_valid_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      afull_q       <= afull_d;
      aempty_q      <= aempty_d;
      ovf_q         <= ovf_d;
      udf_q         <= udf_d;
    end
  end

  // Storage is deliberately not reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_rewind.sv
// Scoreboard bench for fifo_sync_rewind: a DEPTH=16 instance for flags and
// mark/rewind, and a DEPTH=10 instance for wrap-around streaming.
module tb_fifo_sync_rewind;

  logic clk;
  logic rst_n;

  logic        wr_en, rd_en, rd_mark, rd_rewind, rd_release;
  logic [15:0] data_in, data_out;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  count;

  logic        wr_en_t, rd_en_t;
  logic [15:0] data_in_t, data_out_t;
  logic        rd_valid_t, full_t, empty_t, afull_t, aempty_t, ovf_t, udf_t;
  logic [4:0]  count_t;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp10[$];

  fifo_sync_rewind #(.DATA_WIDTH(16), .DEPTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .rd_valid(rd_valid), .rd_mark(rd_mark), .rd_rewind(rd_rewind),
    .rd_release(rd_release), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_rewind #(.DATA_WIDTH(16), .DEPTH(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_t), .data_in(data_in_t), .rd_en(rd_en_t),
    .data_out(data_out_t), .rd_valid(rd_valid_t), .rd_mark(1'b0), .rd_rewind(1'b0),
    .rd_release(1'b0), .full(full_t), .empty(empty_t), .almost_full(afull_t),
    .almost_empty(aempty_t), .count(count_t), .overflow(ovf_t), .underflow(udf_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock on the DEPTH=16 instance; exp_ok says whether the read must be accepted.
  task automatic drv16(input logic we, input logic [15:0] d, input logic re,
                       input logic mk, input logic rw, input logic rl,
                       input logic exp_ok, input logic [15:0] exp_d);
    wr_en = we; data_in = d; rd_en = re;
    rd_mark = mk; rd_rewind = rw; rd_release = rl;
    if (exp_ok) exp_q.push_back(exp_d);
    @(posedge clk); #1;
    chk("rd_valid", rd_valid, exp_ok);
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("sb_underrun", 1, 0);
      else                   chk("rd_data", data_out, exp_q.pop_front());
    end else if (exp_ok && exp_q.size() > 0) begin
      void'(exp_q.pop_back());
    end
    wr_en = 0; rd_en = 0; rd_mark = 0; rd_rewind = 0; rd_release = 0;
  endtask

  task automatic wr16(input logic [15:0] d);
    drv16(1, d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd16(input logic [15:0] e);
    drv16(0, 0, 1, 0, 0, 0, 1, e);
  endtask

  task automatic reset16();
    rst_n = 0;
    drv16(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    wr_en = 0; rd_en = 0; rd_mark = 0; rd_rewind = 0; rd_release = 0; data_in = '0;
    wr_en_t = 0; rd_en_t = 0; data_in_t = '0;
    drv16(0, 0, 0, 0, 0, 0, 0, 0);
    reset16();

    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_empty10", empty_t, 1);

    // DEPTH=10 interleaved stream with wrap
    begin
      int m = 0, wi = 0, ri = 0, seen = 0, cyc = 0;
      bit we, re, wacc, racc;
      while (seen < 25 && cyc < 600) begin
        we = (wi < 25) && ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 1) == 1);
        wacc = we && (m < 10);
        racc = re && (m > 0);
        wr_en_t = we; data_in_t = 16'(wi); rd_en_t = re;
        if (racc) begin exp10.push_back(16'(ri)); ri++; end
        if (wacc) wi++;
        m = m + int'(wacc) - int'(racc);
        @(posedge clk); #1;
        chk("t2_valid", rd_valid_t, racc);
        if (rd_valid_t && exp10.size() > 0) begin
          chk("t2_data", data_out_t, exp10.pop_front());
          seen++;
        end
        chk("t2_count", count_t, m);
        chk("t2_max", (count_t <= 10), 1);
        cyc++;
      end
      wr_en_t = 0; rd_en_t = 0;
      chk("t2_done", seen, 25);
      chk("t2_empty", empty_t, (m == 0));
    end

    // fill, thresholds, drain
    for (int i = 0; i < 16; i++) begin
      wr16(16'(i));
      chk("t1_afull", almost_full, (i + 1) >= 14);
      chk("t1_aempty", almost_empty, (i + 1) <= 2);
    end
    chk("t1_full", full, 1);
    chk("t1_count", count, 16);
    for (int i = 0; i < 16; i++) rd16(16'(i));
    chk("t1_empty", empty, 1);
    chk("t1_full_after", full, 0);

    // read from empty
    drv16(0, 0, 1, 0, 0, 0, 0, 0);
    chk("t5_udf", underflow, 1);
    chk("t5_dout_hold", data_out, 15);

    // full with simultaneous read and write
    reset16();
    chk("t3_udf_cleared", underflow, 0);
    for (int i = 0; i < 16; i++) wr16(16'(100 + i));
    drv16(1, 999, 1, 0, 0, 0, 1, 100);
    chk("t3_ovf", overflow, 1);
    chk("t3_count", count, 15);
    chk("t3_full", full, 0);
    for (int i = 1; i < 16; i++) rd16(16'(100 + i));
    chk("t3_empty", empty, 1);

    // mark / rewind / release
    reset16();
    for (int i = 0; i < 16; i++) wr16(16'(200 + i));
    for (int i = 0; i < 3; i++) rd16(16'(200 + i));
    chk("t4_count13", count, 13);
    drv16(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 3; i < 7; i++) rd16(16'(200 + i));
    chk("t4_count9", count, 9);
    chk("t4_held_not_full", full, 0);
    for (int i = 0; i < 3; i++) wr16(16'(300 + i));
    chk("t4_full_marked", full, 1);
    chk("t4_afull_marked", almost_full, 1);
    chk("t4_count12", count, 12);
    wr16(777);
    chk("t4_ovf", overflow, 1);
    drv16(0, 0, 1, 0, 1, 0, 0, 0);
    chk("t4_rw_count", count, 16);
    chk("t4_rw_udf", underflow, 0);
    for (int i = 3; i < 7; i++) rd16(16'(200 + i));
    chk("t4_still_full", full, 1);
    drv16(0, 0, 0, 0, 0, 1, 0, 0);
    chk("t4_rel_full", full, 0);
    chk("t4_rel_afull", almost_full, 0);
    chk("t4_rel_count", count, 12);
    for (int i = 7; i < 16; i++) rd16(16'(200 + i));
    for (int i = 0; i < 3; i++) rd16(16'(300 + i));
    chk("t4_empty", empty, 1);

    // reset mid-stream
    wr16(10); wr16(11); wr16(12);
    rd16(10);
    rst_n = 0;
    drv16(1, 55, 1, 0, 0, 0, 0, 0);
    rst_n = 1;
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_full", full, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_udf", underflow, 0);
    chk("t6_dout", data_out, 0);
    wr16(42);
    rd16(42);
    chk("t6_empty_after", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
